// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control, counter and display stages.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam int RTC_HZ = 100;

  // Defaults tuned for the 100 Hz real-time clock (40 ms debounce, 5 s lap hold)
  localparam int DEF_DEB_TICKS      = 4;
  localparam int DEF_DEB_W          = 3;
  localparam int DEF_LAP_HOLD_TICKS = 5 * RTC_HZ;

endpackage

// File: rtl/stopwatch_ctrl_fsm_if.sv
// Front-panel bus: raw buttons in, counter controls and status out.
// The slave side is the control FSM; the master side is the panel/counter environment.
interface stopwatch_ctrl_fsm_if;
  import stopwatch_pkg::*;

  logic      i_btn_start;
  logic      i_btn_lap;
  logic      o_countenb;
  logic      o_countinit;
  logic      o_latchcount;
  sw_state_t o_state;
  logic [1:0] o_btn_level;  // accepted (debounced) levels {lap, start}, for debug LEDs

  modport master (
    output i_btn_start,
    output i_btn_lap,
    input  o_countenb,
    input  o_countinit,
    input  o_latchcount,
    input  o_state,
    input  o_btn_level
  );

  modport slave (
    input  i_btn_start,
    input  i_btn_lap,
    output o_countenb,
    output o_countinit,
    output o_latchcount,
    output o_state,
    output o_btn_level
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchroniser, stability counter, one-cycle press pulse on accepted 0->1.
module btn_debounce #(
  parameter int DEB_TICKS = 4,
  parameter int DEB_W     = 3
) (
  input  logic i_rtcclk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;

  // The counter only runs while the synchronised sample disagrees with the accepted level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_W'(DEB_TICKS - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_rtcclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch front-panel control: two debounced buttons drive the IDLE/RUN/LAP/STOP mode FSM.
// Optional macro LAP_AUTOREL_EN adds a lap hold counter that returns LAP to RUN after LAP_HOLD_TICKS.
module stopwatch_ctrl_fsm
  import stopwatch_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS,
  parameter int DEB_W     = DEF_DEB_W
`ifdef LAP_AUTOREL_EN
  ,
  parameter int LAP_HOLD_TICKS = DEF_LAP_HOLD_TICKS
`endif
) (
  input  logic                 i_rtcclk,
  input  logic                 rst,
  stopwatch_ctrl_fsm_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_LAP  = LAP;
  localparam logic [1:0] ST_STOP = STOP;

  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic       start_p;
  logic       lap_p;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       countenb_q;
  logic       countinit_q;
  logic       latchcount_q;
  logic       hold_done;

  assign btn_raw = {bus.i_btn_lap, bus.i_btn_start};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEB_TICKS (DEB_TICKS),
        .DEB_W     (DEB_W)
      ) u_deb (
        .i_rtcclk (i_rtcclk),
        .rst      (rst),
        .i_raw    (btn_raw[gi]),
        .o_level  (btn_level[gi]),
        .o_press  (btn_press[gi])
      );
    end
  endgenerate

  assign start_p = btn_press[0];
  assign lap_p   = btn_press[1];

`ifdef LAP_AUTOREL_EN
  localparam int HOLD_W = $clog2(LAP_HOLD_TICKS + 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_inc;

  // Held at zero outside LAP, so entering LAP always starts a fresh hold interval
  assign hold_inc  = hold_q + 1'b1;
  assign hold_done = (state_q == ST_LAP) && (hold_inc == HOLD_W'(LAP_HOLD_TICKS));
  assign hold_d    = (state_q == ST_LAP) ? hold_inc : '0;

  always_ff @(posedge i_rtcclk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_done = 1'b0;
`endif

  // Start is tested first in every state, so a coincident lap pulse is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_p)    state_d = ST_STOP;
        else if (lap_p) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (start_p)        state_d = ST_STOP;
        else if (lap_p)     state_d = ST_RUN;
        else if (hold_done) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (start_p)    state_d = ST_RUN;
        else if (lap_p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge i_rtcclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      countenb_q   <= 1'b0;
      countinit_q  <= 1'b0;
      latchcount_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      countenb_q   <= (state_d == ST_RUN) || (state_d == ST_LAP);
      countinit_q  <= (state_q == ST_STOP) && (state_d == ST_IDLE);
      latchcount_q <= (state_d != ST_LAP);
    end
  end

  assign bus.o_countenb   = countenb_q;
  assign bus.o_countinit  = countinit_q;
  assign bus.o_latchcount = latchcount_q;
  assign bus.o_state      = sw_state_t'(state_q);
  assign bus.o_btn_level  = btn_level;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed bench for stopwatch_ctrl_fsm: debounce timing, mode sequence, reset and lap behaviour.
module tb_stopwatch_ctrl_fsm;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   init_seen;
  int   last_init;

  stopwatch_ctrl_fsm_if bus ();

  stopwatch_ctrl_fsm #(
    .DEB_TICKS (4),
    .DEB_W     (3)
`ifdef LAP_AUTOREL_EN
    ,
    .LAP_HOLD_TICKS (10)
`endif
  ) dut (
    .i_rtcclk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.o_countinit) init_seen++;
  endtask

  // Hold the buttons long enough for one accepted press (state moves on the 7th edge), then release
  task automatic press(input logic s, input logic l);
    bus.i_btn_start = s;
    bus.i_btn_lap   = l;
    repeat (7) tick();
    last_init = int'(bus.o_countinit);
    bus.i_btn_start = 1'b0;
    bus.i_btn_lap   = 1'b0;
    repeat (7) tick();
  endtask

  task automatic chk_outputs(input string tag, input int st, input int enb, input int latch);
    chk({tag, "_state"}, int'(bus.o_state), st);
    chk({tag, "_countenb"}, int'(bus.o_countenb), enb);
    chk({tag, "_latch"}, int'(bus.o_latchcount), latch);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    init_seen = 0;
    last_init = 0;
    rst = 1'b1;
    bus.i_btn_start = 1'b0;
    bus.i_btn_lap   = 1'b0;
    repeat (3) tick();

    // Reset values
    chk_outputs("rst", 0, 0, 1);
    chk("rst_countinit", int'(bus.o_countinit), 0);
    chk("rst_level", int'(bus.o_btn_level), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Lap in IDLE and 3-cycle glitches are ignored
    press(1'b0, 1'b1);
    chk_outputs("idle_lap", 0, 0, 1);
    bus.i_btn_start = 1'b1;
    repeat (3) tick();
    bus.i_btn_start = 1'b0;
    bus.i_btn_lap   = 1'b1;
    repeat (3) tick();
    bus.i_btn_lap   = 1'b0;
    repeat (10) tick();
    chk_outputs("glitch", 0, 0, 1);
    chk("glitch_init", init_seen, 0);

    // Bouncing start: alternating for 6 cycles, then stable high
    for (int i = 0; i < 6; i++) begin
      bus.i_btn_start = (i % 2 == 0);
      tick();
    end
    bus.i_btn_start = 1'b1;
    repeat (6) tick();
    chk("bounce_pre", int'(bus.o_state), 0);
    tick();
    chk("bounce_run", int'(bus.o_state), 1);
    repeat (10) tick();
    chk("bounce_hold", int'(bus.o_state), 1);
    bus.i_btn_start = 1'b0;
    repeat (7) tick();

    // Asynchronous reset in RUN takes effect without a clock edge
    init_seen = 0;
    chk("pre_rst_run", int'(bus.o_state), 1);
    rst = 1'b1;
    #1;
    chk_outputs("async_rst", 0, 0, 1);
    chk("async_rst_init", int'(bus.o_countinit), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_state", int'(bus.o_state), 0);
    chk("post_rst_init", init_seen, 0);

    // Full cycle: start, lap, lap, start, lap
    press(1'b1, 1'b0);
    chk_outputs("cyc_run", 1, 1, 1);
    press(1'b0, 1'b1);
    chk_outputs("cyc_lap", 2, 1, 0);
`ifdef LAP_AUTOREL_EN
    repeat (10) tick();
`else
    press(1'b0, 1'b1);
`endif
    chk_outputs("cyc_run2", 1, 1, 1);
    init_seen = 0;
    press(1'b1, 1'b0);
    chk_outputs("cyc_stop", 3, 0, 1);
    chk("cyc_stop_init", last_init, 0);
    press(1'b0, 1'b1);
    chk_outputs("cyc_idle", 0, 0, 1);
    chk("cyc_idle_init_now", last_init, 1);
    chk("cyc_idle_init_count", init_seen, 1);

    // Simultaneous presses in RUN: start wins
    press(1'b1, 1'b0);
    chk("sim_run", int'(bus.o_state), 1);
    init_seen = 0;
    press(1'b1, 1'b1);
    chk_outputs("sim_stop", 3, 0, 1);
    chk("sim_init", init_seen, 0);
    press(1'b0, 1'b1);
    chk("sim_idle", int'(bus.o_state), 0);

    // Lap hold behaviour
    press(1'b1, 1'b0);
    bus.i_btn_lap = 1'b1;
    repeat (7) tick();
    bus.i_btn_lap = 1'b0;
    chk("hold_enter", int'(bus.o_state), 2);
`ifdef LAP_AUTOREL_EN
    repeat (9) tick();
    chk("hold_still_lap", int'(bus.o_state), 2);
    tick();
    chk_outputs("hold_release", 1, 1, 1);
`else
    repeat (1000) tick();
    chk_outputs("hold_persist", 2, 1, 0);
    press(1'b0, 1'b1);
    chk_outputs("hold_exit", 1, 1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
